// File: rtl/unidade_busca.sv
// Redux-V instruction fetch stage: program counter, one-entry instruction
// register with valid/ready handoff to the decoder, branch redirect and halt.
module unidade_busca #(
  parameter logic [7:0] PC_INICIAL = 8'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [7:0] endereco,
  input  logic [7:0] instrucao_mem,
  output logic [7:0] instr_saida,
  output logic [7:0] pc_saida,
  output logic       instr_valida,
  input  logic       pronto,
  input  logic       desvio_en,
  input  logic [7:0] desvio_alvo,
  input  logic       parar,
  output logic       parado
);

  localparam logic ATIVO  = 1'b0;
  localparam logic PARADO = 1'b1;

  logic [7:0] pc;
  logic       estado;
  logic       transferencia;
  logic       carga;

  assign transferencia = instr_valida & pronto;
  // A halt request suppresses the load in the same cycle it is sampled.
  assign carga    = (estado == ATIVO) & ~parar & (~instr_valida | transferencia);
  assign endereco = pc;
  assign parado   = (estado == PARADO);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc           <= PC_INICIAL;
      instr_saida  <= 8'd0;
      pc_saida     <= 8'd0;
      instr_valida <= 1'b0;
      estado       <= ATIVO;
    end else if (desvio_en) begin
      // Redirect wins over everything; any IR entry is dropped (a transfer
      // happening this cycle still completes on the decoder side).
      pc           <= desvio_alvo;
      instr_valida <= 1'b0;
      estado       <= ATIVO;
    end else begin
      if (carga) begin
        instr_saida  <= instrucao_mem;
        pc_saida     <= pc;
        instr_valida <= 1'b1;
        pc           <= pc + 8'd1;
      end else if (transferencia) begin
        instr_valida <= 1'b0;
      end
      if ((estado == ATIVO) && parar) begin
        estado <= PARADO;
      end
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: behavioural instruction memory, per-scenario tasks,
// expected fetch addresses queued and popped as instructions appear.
module tb_unidade_busca;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] endereco;
  logic [7:0] instrucao_mem;
  logic [7:0] instr_saida;
  logic [7:0] pc_saida;
  logic       instr_valida;
  logic       pronto;
  logic       desvio_en;
  logic [7:0] desvio_alvo;
  logic       parar;
  logic       parado;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] fila[$];

  always #5 clock = ~clock;

  function automatic logic [7:0] memv(input logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  assign instrucao_mem = memv(endereco);

  unidade_busca #(.PC_INICIAL(8'd0)) dut (
    .clock(clock), .reset_n(reset_n), .endereco(endereco),
    .instrucao_mem(instrucao_mem), .instr_saida(instr_saida),
    .pc_saida(pc_saida), .instr_valida(instr_valida), .pronto(pronto),
    .desvio_en(desvio_en), .desvio_alvo(desvio_alvo), .parar(parar),
    .parado(parado)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pronto = 1'b1; desvio_en = 1'b0; desvio_alvo = 8'd0; parar = 1'b0;
    step(); step();
    n_assert++;
    if ({instr_valida, instr_saida, pc_saida, parado, endereco} !== {1'b0, 8'd0, 8'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%0b i=%h p=%0d parado=%0b end=%0d want v=0 i=00 p=0 parado=0 end=0",
               instr_valida, instr_saida, pc_saida, parado, endereco);
    end
    reset_n = 1'b1;
    step();
    n_assert++;
    if ({instr_valida, instr_saida, pc_saida} !== {1'b1, memv(8'd0), 8'd0}) begin
      n_fail++;
      $display("FAIL first_fetch got v=%0b i=%h p=%0d want v=1 i=%h p=0",
               instr_valida, instr_saida, pc_saida, memv(8'd0));
    end
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    int cyc;
    do_reset();
    pronto = 1'b1;
    for (int i = 0; i < 40; i++) fila.push_back(i[7:0]);
    cyc = 0;
    while (fila.size() > 0 && cyc < 60) begin
      step();
      cyc++;
      if (instr_valida) begin
        a = fila.pop_front();
        n_assert++;
        if ({pc_saida, instr_saida} !== {a, memv(a)}) begin
          n_fail++;
          $display("FAIL seq_fetch got p=%0d i=%h want p=%0d i=%h", pc_saida, instr_saida, a, memv(a));
        end
      end
    end
    n_assert++;
    if (cyc != 40) begin
      n_fail++;
      $display("FAIL seq_throughput got %0d cycles want 40", cyc);
      fila.delete();
    end
  endtask

  task automatic test_stall();
    do_reset();
    pronto = 1'b1;
    repeat (6) step();
    pronto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++;
      if ({instr_valida, pc_saida, instr_saida, endereco} !== {1'b1, 8'd5, memv(8'd5), 8'd6}) begin
        n_fail++;
        $display("FAIL stall_hold got v=%0b p=%0d i=%h end=%0d want v=1 p=5 i=%h end=6",
                 instr_valida, pc_saida, instr_saida, endereco, memv(8'd5));
      end
    end
    pronto = 1'b1;
    step();
    n_assert++;
    if ({instr_valida, pc_saida, instr_saida} !== {1'b1, 8'd6, memv(8'd6)}) begin
      n_fail++;
      $display("FAIL stall_resume got v=%0b p=%0d i=%h want v=1 p=6", instr_valida, pc_saida, instr_saida);
    end
  endtask

  task automatic test_branch(input logic [7:0] alvo, input int n);
    logic [7:0] a;
    desvio_en = 1'b1; desvio_alvo = alvo;
    step();
    desvio_en = 1'b0;
    n_assert++;
    if ({instr_valida, endereco} !== {1'b0, alvo}) begin
      n_fail++;
      $display("FAIL branch_flush got v=%0b end=%0d want v=0 end=%0d", instr_valida, endereco, alvo);
    end
    for (int i = 0; i < n; i++) fila.push_back(alvo + i[7:0]);
    for (int i = 0; i < n; i++) begin
      step();
      a = fila.pop_front();
      n_assert++;
      if ({instr_valida, pc_saida, instr_saida} !== {1'b1, a, memv(a)}) begin
        n_fail++;
        $display("FAIL branch_stream got v=%0b p=%0d i=%h want v=1 p=%0d i=%h",
                 instr_valida, pc_saida, instr_saida, a, memv(a));
      end
    end
  endtask

  task automatic test_desvio();
    do_reset();
    pronto = 1'b1;
    repeat (10) step();
    n_assert++;
    if (endereco !== 8'd10) begin
      n_fail++;
      $display("FAIL branch_setup got end=%0d want 10", endereco);
    end
    test_branch(8'd41, 3);
    test_branch(8'd254, 4);
  endtask

  task automatic test_halt();
    do_reset();
    pronto = 1'b1;
    repeat (3) step();
    pronto = 1'b0;
    step();
    parar = 1'b1;
    step();
    n_assert++;
    if ({parado, instr_valida, pc_saida, endereco} !== {1'b1, 1'b1, 8'd2, 8'd3}) begin
      n_fail++;
      $display("FAIL halt_enter got parado=%0b v=%0b p=%0d end=%0d want 1 1 2 3",
               parado, instr_valida, pc_saida, endereco);
    end
    step();
    pronto = 1'b1;
    step();
    n_assert++;
    if ({parado, instr_valida, endereco} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL halt_drain got parado=%0b v=%0b end=%0d want 1 0 3", parado, instr_valida, endereco);
    end
    parar = 1'b0;
    repeat (2) step();
    n_assert++;
    if ({parado, instr_valida, endereco} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL halt_hold got parado=%0b v=%0b end=%0d want 1 0 3", parado, instr_valida, endereco);
    end
    desvio_en = 1'b1; desvio_alvo = 8'd3;
    step();
    desvio_en = 1'b0;
    n_assert++;
    if ({parado, instr_valida} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_exit got parado=%0b v=%0b want 0 0", parado, instr_valida);
    end
    step();
    n_assert++;
    if ({instr_valida, pc_saida, instr_saida} !== {1'b1, 8'd3, memv(8'd3)}) begin
      n_fail++;
      $display("FAIL halt_refetch got v=%0b p=%0d i=%h want v=1 p=3 i=%h",
               instr_valida, pc_saida, instr_saida, memv(8'd3));
    end
  endtask

  task automatic test_parar_desvio();
    pronto = 1'b1;
    parar = 1'b1; desvio_en = 1'b1; desvio_alvo = 8'd20;
    step();
    parar = 1'b0; desvio_en = 1'b0;
    n_assert++;
    if ({parado, instr_valida} !== 2'b00) begin
      n_fail++;
      $display("FAIL both_flush got parado=%0b v=%0b want 0 0", parado, instr_valida);
    end
    step();
    n_assert++;
    if ({parado, instr_valida, pc_saida, instr_saida} !== {1'b0, 1'b1, 8'd20, memv(8'd20)}) begin
      n_fail++;
      $display("FAIL both_target got parado=%0b v=%0b p=%0d i=%h want 0 1 20 %h",
               parado, instr_valida, pc_saida, instr_saida, memv(8'd20));
    end
  endtask

  task automatic test_reset_mid();
    pronto = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    n_assert++;
    if ({instr_valida, instr_saida, pc_saida, parado, endereco} !== {1'b0, 8'd0, 8'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_stall got v=%0b i=%h p=%0d parado=%0b end=%0d want all zero",
               instr_valida, instr_saida, pc_saida, parado, endereco);
    end
    reset_n = 1'b1;
    pronto = 1'b1;
    repeat (3) step();
    parar = 1'b1;
    step();
    parar = 1'b0;
    reset_n = 1'b0;
    step();
    n_assert++;
    if ({parado, instr_valida, endereco} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_parado got parado=%0b v=%0b end=%0d want 0 0 0", parado, instr_valida, endereco);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_desvio();
    test_halt();
    test_parar_desvio();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch stage of the Redux-V processor: holds the program counter, drives the 8-bit address of the instruction memory, and registers the returned 8-bit instruction into a one-entry instruction register. That register is presented to the decoder through a valid/ready handshake. The stage also supports branch redirection with pipeline flush and a halt/resume mechanism. It sits directly upstream of the instruction memory (address side) and captures its combinational output (data side).

## Interface
- PC_INICIAL, 8'd0, program-counter value loaded at reset (e.g. 8'd41 starts the second program image)
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock
- endereco  out  8  address to instruction memory, equal to the pc register (combinational from register, no logic on path)
- instrucao_mem  in  8  instruction returned combinationally by instruction memory for endereco
- instr_saida  out  8  registered instruction offered to decoder
- pc_saida  out  8  address from which instr_saida was fetched
- instr_valida  out  1  instr_saida/pc_saida hold a valid instruction
- pronto  in  1  decoder accepts instr_saida this cycle when instr_valida=1
- desvio_en  in  1  branch/jump request, one-cycle pulse
- desvio_alvo  in  8  branch target address, valid with desvio_en
- parar  in  1  halt request
- parado  out  1  stage is in PARADO state

## Operation
- Internal state: pc[7:0], IR (instr_saida, pc_saida, instr_valida), FSM state {ATIVO, PARADO}.
- Transfer: accepted when instr_valida=1 and pronto=1.
- Load condition (ATIVO, no desvio_en): IR empty (instr_valida=0) or transfer this cycle. On load, instr_saida<=instrucao_mem, pc_saida<=pc, instr_valida<=1, pc<=pc+1.
- Stall: instr_valida=1, pronto=0. IR and pc hold; endereco stable.
- pc arithmetic is modulo 256: 8'd255 + 1 -> 8'd0, no flag.
- Branch (desvio_en=1, any state): pc<=desvio_alvo, instr_valida<=0 (IR flushed, even if pronto=1 that cycle the transfer still completes to the decoder), state<=ATIVO. Fetch from target occurs the following cycle. Highest priority.
- Halt (parar=1, desvio_en=0, state ATIVO): state<=PARADO. No load that cycle. pc holds.
- PARADO: no loads, pc holds. A pending IR entry remains valid until transferred, then instr_valida<=0. parado=1. parar ignored. Exit only via desvio_en or reset.
- parar and desvio_en in the same cycle: branch taken, halt discarded, state ATIVO.
- Memory content at unwritten addresses is not interpreted; end of program is signalled by the surrounding control via parar.

## Timing
- Reset (reset_n=0 at a rising edge): pc=PC_INICIAL, instr_saida=8'd0, pc_saida=8'd0, instr_valida=0, state=ATIVO, parado=0. Takes effect on that edge regardless of activity, including mid-stall, mid-branch, or PARADO.
- endereco=PC_INICIAL during and immediately after reset.
- Fetch latency: instruction at address A appears on instr_saida one edge after endereco=A with a load condition true.
- First edge after reset release: instr_valida=1, instr_saida=mem[PC_INICIAL].
- Throughput: one instruction per cycle while pronto=1.
- Branch penalty: desvio_en at edge N -> instr_valida=0 after N, target instruction valid after N+1.
- parado asserts the edge after parar is sampled; deasserts the edge after desvio_en is sampled.

## Test plan
- Reset with PC_INICIAL=0, pronto=1 held, memory image 0..39 -> instr_saida sequence mem[0], mem[1], … one per cycle; pc_saida 0,1,2,…; first valid one edge after reset release.
- pronto=0 for 3 cycles while instr_valida=1 at pc_saida=5 -> instr_saida, pc_saida, and endereco=6 frozen. pronto=1 resumes with pc_saida=6 next.
- desvio_en=1, desvio_alvo=8'd41 at pc=10 -> next cycle instr_valida=0; following cycle instr_saida=mem[41], pc_saida=41.
- pc=8'd255 with continuous fetch -> pc_saida 255 then 0, no stall.
- parar=1 with IR valid and pronto=0 -> parado=1 next edge, IR held. pronto=1 -> instr_valida=0, pc constant. desvio_en (alvo=3) -> parado=0, mem[3] valid one cycle later.
- parar and desvio_en together (alvo=20) -> parado stays 0, pc_saida=20 one cycle later. reset_n=0 mid-stall -> all outputs return to reset values on that edge.
